// File: rtl/disp_pkg.sv
// Shared constants for the 7-segment scan controller: segment patterns,
// bit ordering (bit6=a ... bit0=g) and the scan state encoding.
package disp_pkg;

  localparam int SEG_A = 6;
  localparam int SEG_B = 5;
  localparam int SEG_C = 4;
  localparam int SEG_D = 3;
  localparam int SEG_E = 2;
  localparam int SEG_F = 1;
  localparam int SEG_G = 0;

  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  typedef enum logic {SCAN = 1'b0, IDLE = 1'b1} scan_state_e;

endpackage

// File: rtl/seg7_encode.sv
// Combinational BCD nibble to active-high segment pattern; codes above 9
// produce a dark digit and raise invalid.
module seg7_encode
  import disp_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o,
  output logic       invalid_o
);

  always_comb begin
    invalid_o = 1'b0;
    case (nib_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: begin
        seg_o     = SEG_BLANK;
        invalid_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/disp_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with a shared encoder,
// frame-synchronous double-buffered loads and leading-zero blanking.
module disp_scan_ctrl
  import disp_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 1000,
  parameter int CNT_W       = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic                    blank_lz,
  output logic                    load_ack,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic [6:0]              seg,
  output logic                    bcd_err
);

  localparam int IDX_W = $clog2(NUM_DIGITS);

  scan_state_e                 st;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [NUM_DIGITS-1:0][3:0]  shadow_q, active_q, active_d;
  logic                        pending_q, pending_d;
  logic                        ack_q;
  logic [NUM_DIGITS-1:0]       sel_q, sel_d;
  logic [6:0]                  seg_q, seg_d;
  logic                        err_q, err_d;
  logic                        cnt_wrap, idx_last, frame_edge, xfer;
  logic [NUM_DIGITS-1:0]       lz_vec;
  logic                        lz_run, blanked, show;
  logic [3:0]                  nib;
  logic [6:0]                  enc_seg;
  logic                        enc_inv;

  assign st       = en ? SCAN : IDLE;
  assign cnt_wrap = (cnt_q == CNT_W'(REFRESH_DIV - 1));
  assign idx_last = (idx_q == IDX_W'(NUM_DIGITS - 1));

  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    if (st == SCAN) begin
      if (cnt_wrap) begin
        cnt_d = '0;
        idx_d = idx_last ? '0 : idx_q + 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // While idle there is no frame to tear, so a pending value goes live at once.
  assign frame_edge = (st == SCAN) && cnt_wrap && idx_last;
  assign xfer       = pending_q && (frame_edge || (st == IDLE));
  assign active_d   = xfer ? shadow_q : active_q;
  assign pending_d  = load | (pending_q & ~xfer);

  // Scan from the most significant digit down; a digit is a leading zero while
  // every digit above it is also zero. Digit 0 always lights.
  always_comb begin
    lz_run = 1'b1;
    lz_vec = '0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      lz_run    = lz_run && (active_q[i] == 4'd0);
      lz_vec[i] = lz_run;
    end
  end

  assign nib     = active_q[idx_d];
  assign blanked = blank_lz && lz_vec[idx_d];

  seg7_encode u_enc (
    .nib_i     (nib),
    .seg_o     (enc_seg),
    .invalid_o (enc_inv)
  );

  always_comb begin
    sel_d = '0;
    if ((st == SCAN) && (cnt_d != '0)) sel_d[idx_d] = 1'b1;
  end

  assign show  = (sel_d != '0) && !blanked;
  assign seg_d = show ? enc_seg : SEG_BLANK;
  assign err_d = err_q | (show & enc_inv);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      shadow_q  <= '0;
      active_q  <= '0;
      pending_q <= 1'b0;
      ack_q     <= 1'b0;
      sel_q     <= '0;
      seg_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      if (load) shadow_q <= bcd_in;
      active_q  <= active_d;
      pending_q <= pending_d;
      ack_q     <= xfer;
      sel_q     <= sel_d;
      seg_q     <= seg_d;
      err_q     <= err_d;
    end
  end

  assign load_ack  = ack_q;
  assign digit_sel = sel_q;
  assign seg       = seg_q;
  assign bcd_err   = err_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Directed bench for disp_scan_ctrl with NUM_DIGITS=4, REFRESH_DIV=4.
module tb_disp_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset, en, load, blank_lz;
  logic [15:0] bcd_in;
  logic        load_ack, bcd_err;
  logic [3:0]  digit_sel;
  logic [6:0]  seg;

  int n_assert = 0;
  int n_fail   = 0;
  int acks;

  disp_scan_ctrl #(.NUM_DIGITS(4), .REFRESH_DIV(4), .CNT_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .load      (load),
    .bcd_in    (bcd_in),
    .blank_lz  (blank_lz),
    .load_ack  (load_ack),
    .digit_sel (digit_sel),
    .seg       (seg),
    .bcd_err   (bcd_err)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] esel, input logic [6:0] eseg);
    chk({tag, ".sel"}, 16'(digit_sel), 16'(esel));
    chk({tag, ".seg"}, 16'(seg), 16'(eseg));
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; load = 1'b0; blank_lz = 1'b1; bcd_in = 16'h0;
    tick(2);
    chk_out("rst", 4'b0000, 7'b0000000);
    chk("rst.ack", 16'(load_ack), 16'd0);
    chk("rst.err", 16'(bcd_err), 16'd0);

    // Free-running scan of value 0 with blanking on.
    reset = 1'b0; en = 1'b1;
    tick(1);  chk_out("k1", 4'b0001, 7'b1111110);
    tick(3);  chk_out("k4_dead", 4'b0000, 7'b0000000);
    tick(1);  chk_out("k5_blank", 4'b0010, 7'b0000000);
    tick(4);  chk_out("k9_blank", 4'b0100, 7'b0000000);
    tick(4);  chk_out("k13_blank", 4'b1000, 7'b0000000);
    blank_lz = 1'b0;
    tick(1);  chk_out("k14_noblank", 4'b1000, 7'b1111110);

    // Mid-frame load of 1234.
    load = 1'b1; bcd_in = 16'h1234;
    tick(1);  load = 1'b0;
    chk_out("k15_old", 4'b1000, 7'b1111110);
    chk("k15.ack", 16'(load_ack), 16'd0);
    tick(1);  chk("k16.ack", 16'(load_ack), 16'd1);
    chk("k16.sel", 16'(digit_sel), 16'd0);
    tick(1);  chk("k17.ack", 16'(load_ack), 16'd0);
    chk_out("k17_d0", 4'b0001, 7'b0110011);
    tick(12); chk_out("k29_d3", 4'b1000, 7'b0110000);

    // Two loads in one frame: one ack, last value wins.
    blank_lz = 1'b1;
    load = 1'b1; bcd_in = 16'h0007;
    tick(1);  bcd_in = 16'h0042;
    tick(1);  load = 1'b0;
    acks = 0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (load_ack) acks++;
    end
    chk("dbl.acks", 16'(acks), 16'd1);
    tick(2);  chk_out("k41_d2", 4'b0100, 7'b0000000);
    tick(4);  chk_out("k45_d3", 4'b1000, 7'b0000000);
    tick(4);  chk_out("k49_d0", 4'b0001, 7'b1101101);
    tick(4);  chk_out("k53_d1", 4'b0010, 7'b0110011);

    // Invalid nibble and sticky error.
    load = 1'b1; bcd_in = 16'h00A5;
    tick(1);  load = 1'b0;
    tick(11); chk_out("k65_d0", 4'b0001, 7'b1011011);
    chk("k65.err", 16'(bcd_err), 16'd0);
    tick(3);  chk("k68.err", 16'(bcd_err), 16'd0);
    tick(1);  chk_out("k69_bad", 4'b0010, 7'b0000000);
    chk("k69.err", 16'(bcd_err), 16'd1);
    load = 1'b1; bcd_in = 16'h0001;
    tick(1);  load = 1'b0;
    tick(11); chk_out("k81_d0", 4'b0001, 7'b0110000);
    tick(4);  chk_out("k85_d1", 4'b0010, 7'b0000000);
    chk("k85.err", 16'(bcd_err), 16'd1);
    reset = 1'b1;
    tick(1);  chk("rst2.err", 16'(bcd_err), 16'd0);
    chk_out("rst2", 4'b0000, 7'b0000000);

    // Pause at idx=2, cnt=1 with a load while idle.
    reset = 1'b0; blank_lz = 1'b0;
    tick(9);  chk_out("p_k9", 4'b0100, 7'b1111110);
    en = 1'b0;
    tick(2);  chk_out("p_idle", 4'b0000, 7'b0000000);
    load = 1'b1; bcd_in = 16'h0008;
    tick(1);  load = 1'b0;
    chk("p_cap.ack", 16'(load_ack), 16'd0);
    tick(1);  chk("p_xfer.ack", 16'(load_ack), 16'd1);
    tick(1);  chk("p_after.ack", 16'(load_ack), 16'd0);
    tick(5);  chk_out("p_idle_end", 4'b0000, 7'b0000000);
    en = 1'b1;
    tick(1);  chk_out("r_cnt2", 4'b0100, 7'b1111110);
    tick(1);  chk("r_cnt3.sel", 16'(digit_sel), 16'b0100);
    tick(1);  chk("r_dead.sel", 16'(digit_sel), 16'b0000);
    tick(1);  chk("r_d3.sel", 16'(digit_sel), 16'b1000);
    tick(4);  chk_out("r_d0", 4'b0001, 7'b1111111);

    // Reset with a load pending: no ack, active cleared.
    load = 1'b1; bcd_in = 16'h9999;
    tick(1);  load = 1'b0;
    reset = 1'b1;
    tick(1);  chk_out("rp", 4'b0000, 7'b0000000);
    chk("rp.ack", 16'(load_ack), 16'd0);
    reset = 1'b0;
    tick(1);  chk_out("rp_k1", 4'b0001, 7'b1111110);
    acks = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (load_ack) acks++;
    end
    chk("rp.acks", 16'(acks), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
